ray_dispatcher: RTL

Per-frame ray scheduler sitting directly upstream of `voxel_traversal_unit`. On `start_in` it walks every pixel in raster order and, for each pixel, drives the VTU's ray origin and direction and restarts the VTU. It then waits for the VTU's hit result, shades it into an RGB565 colour, and writes the colour to the framebuffer over a valid/ready port.

---
 rtl/ray_dispatcher_if.sv | 12 +
 rtl/ray_dispatcher.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ray_dispatcher_if.sv
// Framebuffer write port: one RGB565 pixel per valid/ready handshake.
interface ray_dispatcher_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] px_addr;
   logic [15:0]       px_color;
   logic              px_valid;
   logic              px_ready;

   modport master (output px_addr, px_color, px_valid, input px_ready);
   modport slave  (input px_addr, px_color, px_valid, output px_ready);
endinterface

// File: rtl/ray_dispatcher.sv
// Per-frame raster ray scheduler in front of the voxel traversal unit:
// launches one ray per pixel, shades the hit and writes it to the framebuffer.
module ray_dispatcher #(
   parameter int              H_RES     = 320,
   parameter int              V_RES     = 180,
   parameter int              MAX_WAIT  = 1023,
   parameter logic [15:0]     SKY_COLOR = 16'h867D,
   parameter int              B         = 16,
   parameter int              BT_W      = 8,
   parameter logic [BT_W-1:0] BLOCK_AIR = '0,
   parameter logic [15:0][15:0] PALETTE = {
      16'hFFE0, 16'hF81F, 16'h07FF, 16'h001F, 16'h07E0, 16'hF800, 16'h8410, 16'hC618,
      16'h4208, 16'hA145, 16'h7BE0, 16'h03EF, 16'h780F, 16'hFD20, 16'hFFFF, 16'h0000},
   localparam int             ADDR_W    = $clog2(H_RES*V_RES)
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [2:0][B-1:0]    cam_pos,
   input  logic [2:0][B-1:0]    cam_corner,
   input  logic [2:0][B-1:0]    cam_dx,
   input  logic [2:0][B-1:0]    cam_dy,
   output logic                 vtu_rst,
   output logic [2:0][B-1:0]    ray_origin,
   output logic [2:0][B-1:0]    ray_direction,
   input  logic [BT_W-1:0]      hit,
   input  logic [2:0][B-1:0]    hit_norm,
   input  logic                 hit_valid,
   ray_dispatcher_if.master     fb,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int X_W    = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int Y_W    = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef logic [2:0][B-1:0] vec3_t;
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WRITE} state_t;

   function automatic vec3_t fadd(input vec3_t a, input vec3_t b);
      vec3_t s;
      for (int i = 0; i < 3; i++) s[i] = a[i] + b[i];
      return s;
   endfunction

   // Face shading: top lit fully, sides 3/4, front/back 1/2, bottom 1/4.
   function automatic logic [15:0] shade(input logic [15:0] c, input vec3_t n);
      logic [4:0] r, bl;
      logic [5:0] g;
      r = c[15:11]; g = c[10:5]; bl = c[4:0];
      if (n[1][B-1] || (n[1] == '0)) begin
         if (n[0] != '0) begin
            r = r - (r >> 2); g = g - (g >> 2); bl = bl - (bl >> 2);
         end else if (n[2] != '0) begin
            r = r >> 1; g = g >> 1; bl = bl >> 1;
         end else if (n[1][B-1]) begin
            r = r >> 2; g = g >> 2; bl = bl >> 2;
         end
      end
      return {r, g, bl};
   endfunction

   state_t            r_state, w_next;
   vec3_t             r_pos, r_dx, r_dy, r_dir, r_row_dir;
   vec3_t             r_ray_origin, r_ray_direction;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [WAIT_W-1:0] r_wait;
   logic [ADDR_W-1:0] r_px_addr;
   logic [15:0]       r_px_color;
   logic              r_px_valid, r_vtu_rst, r_busy, r_frame_done;

   logic              w_start, w_timeout, w_accept, w_last, w_eol;
   logic [15:0]       w_shade;
   vec3_t             w_dir_dx, w_row_dy;

   // A start coinciding with frame_done must not retrigger the frame.
   assign w_start   = start_in && !r_frame_done;
   assign w_timeout = (r_wait == WAIT_W'(MAX_WAIT - 1));
   assign w_accept  = r_px_valid && fb.px_ready;
   assign w_eol     = (r_x == X_W'(H_RES - 1));
   assign w_last    = w_eol && (r_y == Y_W'(V_RES - 1));
   assign w_shade   = (hit == BLOCK_AIR) ? SKY_COLOR : shade(PALETTE[hit[3:0]], hit_norm);
   assign w_dir_dx  = fadd(r_dir, r_dx);
   assign w_row_dy  = fadd(r_row_dir, r_dy);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_next = S_LAUNCH;
         S_LAUNCH: w_next = S_WAIT;
         S_WAIT:   if (hit_valid || w_timeout) w_next = S_WRITE;
         S_WRITE:  if (w_accept) w_next = w_last ? S_IDLE : S_LAUNCH;
         default:  w_next = S_IDLE;
      endcase
   end

   // Ray outputs are loaded on the edge entering LAUNCH so the VTU sees them
   // for the whole LAUNCH cycle while its reset is still asserted.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_pos <= '0; r_dx <= '0; r_dy <= '0; r_dir <= '0; r_row_dir <= '0;
         r_ray_origin <= '0; r_ray_direction <= '0;
         r_x <= '0; r_y <= '0; r_wait <= '0;
         r_px_addr <= '0; r_px_color <= '0; r_px_valid <= 1'b0;
         r_vtu_rst <= 1'b1; r_busy <= 1'b0; r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_vtu_rst <= 1'b1;
               if (w_start) begin
                  r_pos <= cam_pos; r_dx <= cam_dx; r_dy <= cam_dy;
                  r_dir <= cam_corner; r_row_dir <= cam_corner;
                  r_ray_origin <= cam_pos; r_ray_direction <= cam_corner;
                  r_x <= '0; r_y <= '0; r_px_addr <= '0;
                  r_busy <= 1'b1;
               end
            end
            S_LAUNCH: begin
               r_vtu_rst <= 1'b0;
               r_wait    <= '0;
            end
            S_WAIT: begin
               if (hit_valid || w_timeout) begin
                  r_px_color <= hit_valid ? w_shade : SKY_COLOR;
                  r_px_valid <= 1'b1;
                  r_vtu_rst  <= 1'b1;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            S_WRITE: begin
               if (w_accept) begin
                  r_px_valid <= 1'b0;
                  if (w_last) begin
                     r_frame_done <= 1'b1;
                     r_busy       <= 1'b0;
                  end else begin
                     r_px_addr <= r_px_addr + ADDR_W'(1);
                     if (!w_eol) begin
                        r_x <= r_x + X_W'(1);
                        r_dir <= w_dir_dx;
                        r_ray_direction <= w_dir_dx;
                     end else begin
                        r_x <= '0;
                        r_y <= r_y + Y_W'(1);
                        r_row_dir <= w_row_dy;
                        r_dir <= fadd(r_row_dir, r_dy);
                        r_ray_direction <= fadd(r_row_dir, r_dy);
                     end
                  end
               end
            end
            default: r_vtu_rst <= 1'b1;
         endcase
      end
   end

   assign vtu_rst       = r_vtu_rst;
   assign ray_origin    = r_ray_origin;
   assign ray_direction = r_ray_direction;
   assign fb.px_addr    = r_px_addr;
   assign fb.px_color   = r_px_color;
   assign fb.px_valid   = r_px_valid;
   assign busy          = r_busy;
   assign frame_done    = r_frame_done;
endmodule
